// File: rtl/axi_pkg.sv
// Shared AXI write-response definitions: resp encodings, the B-beat record
// and the output-slot state type used by the response arbiter.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_EXOKAY = 2'd1;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    // Widest bid carried in a stored beat; narrower ids are zero-extended.
    localparam int AXI_ID_MAX_WIDTH = 16;

    // One write-response beat as held in the output slot.
    typedef struct packed {
        logic [AXI_ID_MAX_WIDTH-1:0] id;
        logic [1:0]                  resp;
        logic                        user;
    } b_beat_t;

    // Occupancy of the single-entry output slot.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // SLVERR and DECERR are the responses that count as errors.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/axi_wr_rsp_channel.sv
// AXI B channel bundle; the master side drives the response, the slave
// side returns ready.
interface axi_wr_rsp_channel #(
    parameter int ID_WIDTH = 16
) ();

    logic                bvalid;
    logic                bready;
    logic [ID_WIDTH-1:0] bid;
    logic [1:0]          bresp;
    logic                buser;

    modport master (output bvalid, bid, bresp, buser, input bready);
    modport slave  (input bvalid, bid, bresp, buser, output bready);

endinterface

// File: rtl/axi_wr_rsp_arbiter_core.sv
// Merges NUM_SRC write-response streams into one through a single registered
// slot. Round-robin selection, one beat per cycle while downstream is ready,
// and a saturating count of delivered error responses.
module axi_wr_rsp_arbiter_core
    import axi_pkg::*;
#(
    parameter  int NUM_SRC      = 4,
    parameter  int ID_MAX_WIDTH = 16,
    parameter  int CNT_WIDTH    = 16,
    localparam int IDX_W        = $clog2(NUM_SRC)
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [NUM_SRC-1:0]              s_bvalid,
    output logic [NUM_SRC-1:0]              s_bready,
    input  logic [NUM_SRC*ID_MAX_WIDTH-1:0] s_bid,
    input  logic [NUM_SRC*2-1:0]            s_bresp,
    input  logic [NUM_SRC-1:0]              s_buser,
    output logic                            m_bvalid,
    input  logic                            m_bready,
    output logic [ID_MAX_WIDTH-1:0]         m_bid,
    output logic [1:0]                      m_bresp,
    output logic                            m_buser,
    output logic [IDX_W-1:0]                m_bsrc,
    output logic [CNT_WIDTH-1:0]            err_cnt,
    input  logic                            err_clr
);

    slot_state_t          state_q, state_d;
    b_beat_t              slot_q, slot_d, granted;
    logic [IDX_W-1:0]     src_q, src_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     grant_idx;
    logic [NUM_SRC-1:0]   grant;
    logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic                 load;
    logic                 m_hs;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC)
    ) u_rr (
        .req       (s_bvalid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Select the granted source's beat; grant is one-hot or all zero.
    always_comb begin
        granted = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                granted.id   = AXI_ID_MAX_WIDTH'(s_bid[i*ID_MAX_WIDTH +: ID_MAX_WIDTH]);
                granted.resp = s_bresp[i*2 +: 2];
                granted.user = s_buser[i];
            end
        end
    end

    // Slot next-state: refill whenever the slot is empty or being drained.
    always_comb begin
        load     = (state_q == SLOT_EMPTY) || m_bready;
        state_d  = state_q;
        slot_d   = slot_q;
        src_d    = src_q;
        rr_ptr_d = rr_ptr_q;
        s_bready = '0;
        if (load) begin
            if (|s_bvalid) begin
                // Ready is also held low while reset is asserted.
                s_bready = grant & {NUM_SRC{aresetn}};
                state_d  = SLOT_FULL;
                slot_d   = granted;
                src_d    = grant_idx;
                rr_ptr_d = (grant_idx == IDX_W'(NUM_SRC - 1)) ? '0 : grant_idx + IDX_W'(1);
            end else begin
                state_d = SLOT_EMPTY;
            end
        end
    end

    // Slot and pointer registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= SLOT_EMPTY;
            // NOTE: the slot payload is reset as well, because m_bid/m_bresp/m_buser/m_bsrc must read zero during reset.
            slot_q   <= '0;
            src_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples the pre-edge values computed above.
            state_q  <= state_d;
            slot_q   <= slot_d;
            src_q    <= src_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign m_hs = (state_q == SLOT_FULL) && m_bready;

    // Error counter: clear wins, otherwise count delivered errors up to all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (m_hs && resp_is_err(slot_q.resp) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
        end
    end

    // Error counter register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign m_bvalid = (state_q == SLOT_FULL);
    assign m_bid    = slot_q.id[ID_MAX_WIDTH-1:0];
    assign m_bresp  = slot_q.resp;
    assign m_buser  = slot_q.user;
    assign m_bsrc   = src_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: rtl/axi_wr_rsp_master_port.sv
// Thin adapter from the core's flat master-side signals onto the master
// modport of an axi_wr_rsp_channel.
module axi_wr_rsp_master_port #(
    parameter int ID_WIDTH = 16
) (
    axi_wr_rsp_channel.master  m,
    input  logic                bvalid,
    input  logic [ID_WIDTH-1:0] bid,
    input  logic [1:0]          bresp,
    input  logic                buser,
    output logic                bready
);

    assign m.bvalid = bvalid;
    assign m.bid    = bid;
    assign m.bresp  = bresp;
    assign m.buser  = buser;
    assign bready   = m.bready;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: search req starting at ptr, wrapping from NUM_SRC-1
// to 0, and return the first requester as one-hot and as an index.
module rr_arbiter #(
    parameter  int NUM_SRC = 4,
    localparam int IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    // One extra bit so ptr + offset cannot overflow before the wrap.
    localparam int PW = IDX_W + 1;

    // Visit every source once in rotated order; the first requester wins.
    always_comb begin
        logic [PW-1:0]    pos;
        logic [IDX_W-1:0] idx;
        logic             found;
        // NOTE: every variable gets a value before the loop, so no path through this block can infer a latch.
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = '0;
        idx       = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            pos = {1'b0, ptr} + PW'(k);
            if (pos >= PW'(NUM_SRC)) begin
                pos = pos - PW'(NUM_SRC);
            end
            idx = pos[IDX_W-1:0];
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/axi_wr_rsp_arbiter.sv
// Write-response arbiter top: flat-port core whose merged output is routed
// through the master side of an axi_wr_rsp_channel bundle.
module axi_wr_rsp_arbiter #(
    parameter int NUM_SRC      = 4,
    parameter int ID_MAX_WIDTH = 16,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [NUM_SRC-1:0]              s_bvalid,
    output logic [NUM_SRC-1:0]              s_bready,
    input  logic [NUM_SRC*ID_MAX_WIDTH-1:0] s_bid,
    input  logic [NUM_SRC*2-1:0]            s_bresp,
    input  logic [NUM_SRC-1:0]              s_buser,
    output logic                            m_bvalid,
    input  logic                            m_bready,
    output logic [ID_MAX_WIDTH-1:0]         m_bid,
    output logic [1:0]                      m_bresp,
    output logic                            m_buser,
    output logic [$clog2(NUM_SRC)-1:0]      m_bsrc,
    output logic [CNT_WIDTH-1:0]            err_cnt,
    input  logic                            err_clr
);

    logic                    core_bvalid;
    logic                    core_bready;
    logic [ID_MAX_WIDTH-1:0] core_bid;
    logic [1:0]              core_bresp;
    logic                    core_buser;

    axi_wr_rsp_channel #(.ID_WIDTH(ID_MAX_WIDTH)) m_ch ();

    axi_wr_rsp_arbiter_core #(
        .NUM_SRC      (NUM_SRC),
        .ID_MAX_WIDTH (ID_MAX_WIDTH),
        .CNT_WIDTH    (CNT_WIDTH)
    ) u_core (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .s_bvalid (s_bvalid),
        .s_bready (s_bready),
        .s_bid    (s_bid),
        .s_bresp  (s_bresp),
        .s_buser  (s_buser),
        .m_bvalid (core_bvalid),
        .m_bready (core_bready),
        .m_bid    (core_bid),
        .m_bresp  (core_bresp),
        .m_buser  (core_buser),
        .m_bsrc   (m_bsrc),
        .err_cnt  (err_cnt),
        .err_clr  (err_clr)
    );

    axi_wr_rsp_master_port #(
        .ID_WIDTH (ID_MAX_WIDTH)
    ) u_mport (
        .m      (m_ch),
        .bvalid (core_bvalid),
        .bid    (core_bid),
        .bresp  (core_bresp),
        .buser  (core_buser),
        .bready (core_bready)
    );

    assign m_bvalid    = m_ch.bvalid;
    assign m_bid       = m_ch.bid;
    assign m_bresp     = m_ch.bresp;
    assign m_buser     = m_ch.buser;
    assign m_ch.bready = m_bready;

endmodule

// File: tb/tb_axi_wr_rsp_arbiter.sv
// Directed and random checks for axi_wr_rsp_arbiter (4 sources, 16-bit ids).
module tb_axi_wr_rsp_arbiter;
    import axi_pkg::*;

    localparam int NUM_SRC = 4;
    localparam int ID_W    = 16;
    localparam int CNT_W   = 16;

    logic                       aclk = 1'b0;
    logic                       aresetn;
    logic [NUM_SRC-1:0]         s_bvalid;
    logic [NUM_SRC-1:0]         s_bready;
    logic [NUM_SRC*ID_W-1:0]    s_bid;
    logic [NUM_SRC*2-1:0]       s_bresp;
    logic [NUM_SRC-1:0]         s_buser;
    logic                       m_bvalid;
    logic                       m_bready;
    logic [ID_W-1:0]            m_bid;
    logic [1:0]                 m_bresp;
    logic                       m_buser;
    logic [1:0]                 m_bsrc;
    logic [CNT_W-1:0]           err_cnt;
    logic                       err_clr;

    int n_cmp  = 0;
    int n_fail = 0;

    b_beat_t            exp_q [NUM_SRC][$];
    logic [11:0]        seq   [NUM_SRC];
    logic [NUM_SRC-1:0] hs_mask;
    int                 model_err;

    always #5 aclk = ~aclk;

    axi_wr_rsp_arbiter #(
        .NUM_SRC      (NUM_SRC),
        .ID_MAX_WIDTH (ID_W),
        .CNT_WIDTH    (CNT_W)
    ) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .s_bvalid (s_bvalid),
        .s_bready (s_bready),
        .s_bid    (s_bid),
        .s_bresp  (s_bresp),
        .s_buser  (s_buser),
        .m_bvalid (m_bvalid),
        .m_bready (m_bready),
        .m_bid    (m_bid),
        .m_bresp  (m_bresp),
        .m_buser  (m_buser),
        .m_bsrc   (m_bsrc),
        .err_cnt  (err_cnt),
        .err_clr  (err_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int i, input logic [ID_W-1:0] id, input logic [1:0] resp, input logic user);
        s_bid[i*ID_W +: ID_W] = id;
        s_bresp[i*2 +: 2]     = resp;
        s_buser[i]            = user;
    endtask

    // One random cycle: retire last cycle's handshakes, offer new beats,
    // then check the merged output against the per-source expected queues.
    task automatic stress_cycle(input bit gen);
        b_beat_t b;
        @(negedge aclk);
        s_bvalid = s_bvalid & ~hs_mask;
        m_bready = gen ? ($urandom_range(0, 9) < 7) : 1'b1;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!gen) begin
                s_bvalid[i] = 1'b0;
            end else if (!s_bvalid[i] && ($urandom_range(0, 1) == 1)) begin
                set_src(i, {4'(i), seq[i]}, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
                seq[i]      = seq[i] + 12'd1;
                s_bvalid[i] = 1'b1;
            end
        end
        #1;
        check("stress_onehot", 32'($onehot0(s_bready)), 32'h1);
        check("stress_rdy_subset", 32'(s_bready & ~s_bvalid), 32'h0);
        if (m_bvalid && m_bready) begin
            check("stress_not_dup", 32'(exp_q[m_bsrc].size() != 0), 32'h1);
            if (exp_q[m_bsrc].size() != 0) begin
                b = exp_q[m_bsrc].pop_front();
                check("stress_bid", 32'(m_bid), 32'(b.id));
                check("stress_bresp", 32'(m_bresp), 32'(b.resp));
                check("stress_buser", 32'(m_buser), 32'(b.user));
                if (b.resp[1]) model_err++;
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (s_bvalid[i] && s_bready[i]) begin
                b.id   = s_bid[i*ID_W +: ID_W];
                b.resp = s_bresp[i*2 +: 2];
                b.user = s_buser[i];
                exp_q[i].push_back(b);
            end
        end
        hs_mask = s_bvalid & s_bready;
    endtask

    initial begin
        aresetn   = 1'b0;
        s_bvalid  = '0;
        s_bid     = '0;
        s_bresp   = '0;
        s_buser   = '0;
        m_bready  = 1'b0;
        err_clr   = 1'b0;
        hs_mask   = '0;
        model_err = 0;
        for (int i = 0; i < NUM_SRC; i++) seq[i] = '0;

        // Reset values.
        repeat (2) @(negedge aclk);
        #1;
        check("rst_m_bvalid", 32'(m_bvalid), 32'h0);
        check("rst_s_bready", 32'(s_bready), 32'h0);
        check("rst_m_bid", 32'(m_bid), 32'h0);
        check("rst_m_bsrc", 32'(m_bsrc), 32'h0);
        check("rst_err_cnt", 32'(err_cnt), 32'h0);

        // Idle after release.
        @(negedge aclk);
        aresetn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge aclk);
            #1;
            check("idle_m_bvalid", 32'(m_bvalid), 32'h0);
            check("idle_s_bready", 32'(s_bready), 32'h0);
            check("idle_err_cnt", 32'(err_cnt), 32'h0);
        end

        // All four sources requesting, downstream always ready.
        for (int i = 0; i < NUM_SRC; i++) set_src(i, 16'h0100 + 16'(i), RESP_OKAY, 1'(i));
        @(negedge aclk);
        s_bvalid = 4'b1111;
        m_bready = 1'b1;
        #1;
        check("rr_first_rdy", 32'(s_bready), 32'h1);
        check("rr_first_vld", 32'(m_bvalid), 32'h0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge aclk);
            #1;
            check("rr_vld", 32'(m_bvalid), 32'h1);
            check("rr_src", 32'(m_bsrc), 32'((k - 1) % 4));
            check("rr_bid", 32'(m_bid), 32'(16'h0100 + 16'((k - 1) % 4)));
            check("rr_user", 32'(m_buser), 32'((k - 1) % 2));
            check("rr_rdy", 32'(s_bready), 32'(1 << (k % 4)));
        end
        @(negedge aclk);
        s_bvalid = '0;
        #1;
        check("rr_tail_src", 32'(m_bsrc), 32'h1);
        check("rr_tail_rdy", 32'(s_bready), 32'h0);
        @(negedge aclk);
        #1;
        check("rr_drained", 32'(m_bvalid), 32'h0);

        // Source 2 alone with a stalled downstream.
        set_src(2, 16'h00A5, RESP_SLVERR, 1'b0);
        @(negedge aclk);
        s_bvalid = 4'b0100;
        m_bready = 1'b0;
        #1;
        check("stall_load_rdy", 32'(s_bready), 32'h4);
        for (int c = 0; c < 3; c++) begin
            @(negedge aclk);
            if (c == 0) set_src(2, 16'h00A6, RESP_OKAY, 1'b1);
            #1;
            check("stall_vld", 32'(m_bvalid), 32'h1);
            check("stall_bid", 32'(m_bid), 32'h00A5);
            check("stall_bresp", 32'(m_bresp), 32'h2);
            check("stall_rdy", 32'(s_bready), 32'h0);
            check("stall_err", 32'(err_cnt), 32'h0);
        end
        @(negedge aclk);
        m_bready = 1'b1;
        #1;
        check("stall_rel_bid", 32'(m_bid), 32'h00A5);
        check("stall_rel_rdy", 32'(s_bready), 32'h4);
        @(negedge aclk);
        s_bvalid = '0;
        #1;
        check("stall_err_one", 32'(err_cnt), 32'h1);
        check("stall_next_bid", 32'(m_bid), 32'h00A6);
        check("stall_next_src", 32'(m_bsrc), 32'h2);
        @(negedge aclk);
        #1;
        check("stall_drained", 32'(m_bvalid), 32'h0);
        check("stall_err_hold", 32'(err_cnt), 32'h1);

        // Error counter saturation, then clear against a DECERR handshake.
        @(negedge aclk);
        err_clr = 1'b1;
        @(negedge aclk);
        err_clr = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) set_src(i, 16'h0200 + 16'(i), RESP_SLVERR, 1'b0);
        s_bvalid = 4'b1111;
        m_bready = 1'b1;
        #1;
        check("sat_cleared", 32'(err_cnt), 32'h0);
        repeat (65535) @(negedge aclk);
        #1;
        check("sat_fffe", 32'(err_cnt), 32'hFFFE);
        @(negedge aclk);
        #1;
        check("sat_ffff", 32'(err_cnt), 32'hFFFF);
        @(negedge aclk);
        #1;
        check("sat_hold", 32'(err_cnt), 32'hFFFF);
        for (int i = 0; i < NUM_SRC; i++) set_src(i, 16'h0300 + 16'(i), RESP_DECERR, 1'b0);
        @(negedge aclk);
        err_clr  = 1'b1;
        s_bvalid = '0;
        #1;
        check("clr_decerr_resp", 32'(m_bresp), 32'h3);
        check("clr_pre", 32'(err_cnt), 32'hFFFF);
        @(negedge aclk);
        err_clr = 1'b0;
        #1;
        check("clr_wins", 32'(err_cnt), 32'h0);
        check("clr_drained", 32'(m_bvalid), 32'h0);

        // Reset while FULL, then first grant must search from source 0.
        set_src(2, 16'h1234, RESP_OKAY, 1'b0);
        @(negedge aclk);
        s_bvalid = 4'b0100;
        m_bready = 1'b0;
        @(negedge aclk);
        s_bvalid = '0;
        #1;
        check("rstf_full", 32'(m_bvalid), 32'h1);
        check("rstf_bid_held", 32'(m_bid), 32'h1234);
        aresetn = 1'b0;
        set_src(1, 16'h0011, RESP_OKAY, 1'b0);
        set_src(3, 16'h0033, RESP_OKAY, 1'b1);
        s_bvalid = 4'b1010;
        m_bready = 1'b1;
        #1;
        check("rstf_vld", 32'(m_bvalid), 32'h0);
        check("rstf_bid", 32'(m_bid), 32'h0);
        check("rstf_src", 32'(m_bsrc), 32'h0);
        check("rstf_rdy", 32'(s_bready), 32'h0);
        check("rstf_err", 32'(err_cnt), 32'h0);
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        check("rstf_first_rdy", 32'(s_bready), 32'h2);
        @(negedge aclk);
        s_bvalid = 4'b1000;
        #1;
        check("rstf_first_src", 32'(m_bsrc), 32'h1);
        check("rstf_first_bid", 32'(m_bid), 32'h0011);
        check("rstf_second_rdy", 32'(s_bready), 32'h8);
        @(negedge aclk);
        s_bvalid = '0;
        #1;
        check("rstf_second_src", 32'(m_bsrc), 32'h3);
        @(negedge aclk);
        #1;
        check("rstf_drained", 32'(m_bvalid), 32'h0);
        check("stress_err_start", 32'(err_cnt), 32'h0);

        // Random valid/ready stress followed by a drain.
        repeat (10000) stress_cycle(1'b1);
        repeat (4) stress_cycle(1'b0);
        for (int i = 0; i < NUM_SRC; i++) begin
            check("stress_lost", 32'(exp_q[i].size()), 32'h0);
        end
        check("stress_err_cnt", 32'(err_cnt), 32'(model_err));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
